// File: rtl/and_gate.sv
// and_gate: bitwise AND with a registered copy, an all-ones flag and a saturating count of non-zero cycles
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out1_q,
  output logic             all_one,
  output logic [CNT_W-1:0] hit_cnt
);
  assign out1 = in1 & in2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_q  <= '0;
      all_one <= 1'b0;
      hit_cnt <= '0;
    end else begin
      out1_q  <= out1;
      all_one <= &out1;
      if (|out1 && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_and_gate.sv
// tb_and_gate: directed vectors on a 1-bit and a 4-bit instance; registered results checked through a scoreboard queue
module tb_and_gate;
  logic clk = 1'b0;
  logic rst_n;
  logic       a1, a2, a_out, a_q, a_all;
  logic [7:0] a_hit;
  logic [3:0] b1, b2, b_out, b_q;
  logic       b_all;
  logic [1:0] b_hit;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic       aq;
    logic       aall;
    logic [7:0] ahit;
    logic [3:0] bq;
    logic       ball;
    logic [1:0] bhit;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  and_gate #(.WIDTH(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in1(a1), .in2(a2),
    .out1(a_out), .out1_q(a_q), .all_one(a_all), .hit_cnt(a_hit)
  );
  and_gate #(.WIDTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in1(b1), .in2(b2),
    .out1(b_out), .out1_q(b_q), .all_one(b_all), .hit_cnt(b_hit)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic ia1, input logic ia2, input logic [3:0] ib1, input logic [3:0] ib2,
                     input logic aq, input logic aall, input logic [7:0] ahit,
                     input logic [3:0] bq, input logic ball, input logic [1:0] bhit);
    a1 = ia1; a2 = ia2; b1 = ib1; b2 = ib2;
    sb.push_back('{aq, aall, ahit, bq, ball, bhit});
    @(negedge clk);
  endtask

  // Monitor: registered outputs settle just after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("a_out1_q", {7'd0, a_q}, {7'd0, e.aq});
        chk("a_all_one", {7'd0, a_all}, {7'd0, e.aall});
        chk("a_hit_cnt", a_hit, e.ahit);
        chk("b_out1_q", {4'd0, b_q}, {4'd0, e.bq});
        chk("b_all_one", {7'd0, b_all}, {7'd0, e.ball});
        chk("b_hit_cnt", {6'd0, b_hit}, {6'd0, e.bhit});
      end
    end
  end

  initial begin
    logic [1:0] vec [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic       res [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; a1 = 1'b0; a2 = 1'b0; b1 = 4'h0; b2 = 4'h0;
    #1;
    chk("rst_a_q", {7'd0, a_q}, 8'd0);
    chk("rst_a_hit", a_hit, 8'd0);
    chk("rst_b_all", {7'd0, b_all}, 8'd0);
    // Truth table while still in reset: combinational path ignores rst_n
    for (int i = 0; i < 4; i++) begin
      {a1, a2} = vec[i];
      #6;
      chk("truth_out1", {7'd0, a_out}, {7'd0, res[i]});
      #1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; a2 = 1'b1; b1 = 4'b1100; b2 = 4'b1010;
    #1;
    chk("b_out1_comb", {4'd0, b_out}, 8'h08);
    #1;
    cyc(1, 1, 4'b1100, 4'b1010, 1, 1, 8'd1, 4'b1000, 0, 2'd1);
    cyc(1, 1, 4'hF,    4'hF,    1, 1, 8'd2, 4'hF,    1, 2'd2);
    cyc(0, 1, 4'hF,    4'h0,    0, 0, 8'd2, 4'h0,    0, 2'd2);
    cyc(1, 1, 4'hF,    4'hF,    1, 1, 8'd3, 4'hF,    1, 2'd3);
    cyc(1, 1, 4'hF,    4'hF,    1, 1, 8'd4, 4'hF,    1, 2'd3);
    cyc(1, 1, 4'b0001, 4'b0011, 1, 1, 8'd5, 4'b0001, 0, 2'd3);
    // Asynchronous reset mid-cycle: registers clear before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_q", {7'd0, a_q}, 8'd0);
    chk("arst_a_all", {7'd0, a_all}, 8'd0);
    chk("arst_a_hit", a_hit, 8'd0);
    chk("arst_a_out1", {7'd0, a_out}, 8'd1);
    chk("arst_b_hit", {6'd0, b_hit}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 4'hF, 4'hF, 0, 0, 8'd0, 4'hF, 1, 2'd1);
    cyc(0, 0, 4'hF, 4'hF, 0, 0, 8'd0, 4'hF, 1, 2'd2);
    cyc(1, 0, 4'hF, 4'hF, 0, 0, 8'd0, 4'hF, 1, 2'd3);
    cyc(0, 1, 4'hF, 4'hF, 0, 0, 8'd0, 4'hF, 1, 2'd3);
    cyc(0, 0, 4'hF, 4'hF, 0, 0, 8'd0, 4'hF, 1, 2'd3);
    cyc(0, 0, 4'hF, 4'hF, 0, 0, 8'd0, 4'hF, 1, 2'd3);
    // Inputs drop before the edge: only the value at the edge is captured
    a1 = 1'b1; a2 = 1'b1; b1 = 4'h0; b2 = 4'h0;
    sb.push_back('{1'b0, 1'b0, 8'd0, 4'h0, 1'b0, 2'd3});
    #1;
    chk("glitch_out1_hi", {7'd0, a_out}, 8'd1);
    #2;
    a2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
